sig_field_serializer: RTL and testbench
=======================================

// Module: sig_field_serializer
// PURPOSE
//  Builds the 24-bit 802.11a SIGNAL field from RATE and LENGTH. Serializes it LSB-first, one bit per accepted transfer.
//  Sits upstream of the convolutional encoder; its internal bit index runs 0..23 and drives the encoder-side bit counter.
//  One frame per request, valid/ready on both sides.
// PARAMETERS
//  RATE_W   4   width of RATE code, {R1,R2,R3,R4}; rate[3]=R1 is sent first
//  LEN_W    12  width of LENGTH in octets; sent LSB first
//  SIG_BITS 24  total field bits = RATE_W + 1 + LEN_W + 1 + 6
// PORTS
//  clk        in   1      rising-edge clock
//  rst        in   1      reset: synchronous, active-low
//  req_valid  in   1      request present
//  req_ready  out  1      block can accept a request
//  rate       in   4      RATE code, sampled on request handshake
//  length     in   12     LENGTH, sampled on request handshake
//  bit_out    out  1      current SIGNAL bit
//  bit_valid  out  1      bit_out valid
//  bit_ready  in   1      downstream accepts bit
//  bit_idx    out  5      index (0..23) of bit currently on bit_out
//  bit_last   out  1      high when bit_idx==23 and bit_valid
//  done       out  1      one-cycle pulse after bit 23 is transferred
//  err        out  1      one-cycle pulse, invalid RATE (only with SIG_RATE_CHECK_EN)
// BEHAVIOUR
//  Reset (rst==0 at posedge): state=IDLE, shift reg=0, bit_idx=0, bit_valid=0, done=0, err=0, bit_out=0.
//   req_ready is forced 0 while rst==0.
//  Field layout (bit 0 first): [3:0] R1..R4; [4] reserved=0; [16:5] LENGTH LSB first;
//   [17] even parity over bits 0..16; [23:18] tail=0.
//  State machine:
//   IDLE: req_ready=1, bit_valid=0. When req_valid&req_ready, load 24-bit field into shift reg, bit_idx=0, go to SEND.
//   SEND: req_ready=0, bit_valid=1, bit_out=sreg[0].
//    - bit_valid&bit_ready with bit_idx<23: shift right 1, bit_idx+1.
//    - bit_valid&bit_ready with bit_idx==23: go to IDLE, bit_idx wraps to 0, done=1 for the next cycle.
//    - No bit_ready: bit_out, bit_idx and bit_valid hold.
//  Latency: request handshake in cycle N; first bit valid in cycle N+1.
//   Full-throughput frame occupies 24 cycles. done is in cycle N+25, when req_ready is already 1.
//   Back-to-back requests therefore cost 1 idle cycle.
//  rate and length are ignored outside the request handshake. Changing them mid-frame has no effect.
//  bit_last is combinational from registered state: (state==SEND)&&(bit_idx==23).
//  Reset mid-frame: frame is abandoned, no done pulse, next cycle is IDLE.
//  Parity: XOR reduction of the 17 header bits, computed at load.
// CONFIGURATION
//  SIG_RATE_CHECK_EN defined:
//   - Valid RATE codes have R4==1: 1101,1111,0101,0111,1001,1011,0001,0011.
//   - Request with R4==0 is consumed (handshake completes) and err pulses in the next cycle.
//   - State stays IDLE; no bits are emitted and no done pulse occurs.
//  Undefined: err is tied 0 and every RATE code is serialized as given.
// STRUCTURE
//  Shared package phy_sig_pkg:
//   - SIG_BITS=24, SIG_PARITY_POS=17, SIG_TAIL_BITS=6, SIG_RESERVED_POS=4
//   - state encoding IDLE/SEND, valid-rate check function
//  Sub-module sig_bit_cnt: 0..23 index counter with run, zero and at_last outputs.
//   It wraps to 0 on run at 23. The synchronous active-low reset here replaces async reset.
//  Top holds the FSM, the 24-bit shift reg and the parity/field assembly.
// TESTING
//  1 rate=1101, length=100, bit_ready=1 -> stream 1101 0 001001100000 0 000000.
//    parity=0, bit_last at 24th bit, done 1 cycle later.
//  2 rate=1111, length=1 -> header ones=5, bit17=1. Stream 1111 0 100000000000 1 000000.
//  3 Test 1 with bit_ready random 50% -> identical 24-bit stream, exactly 24 transfers.
//    bit_out/bit_idx stable on stalled cycles.
//  4 rst=0 at bit_idx=10 -> next cycle IDLE, bit_valid=0, bit_idx=0, no done.
//    A new request then sends a full fresh frame.
//  5 req_valid held high across two frames -> second handshake in the done cycle, 1-cycle gap.
//    rate/length changes mid-frame ignored.
//  6 SIG_RATE_CHECK_EN, rate=0000 -> handshake completes, err=1 for 1 cycle, bit_valid stays 0, no done.
//    Without the macro -> 0000 serialized normally.

Source files
------------

// File: rtl/phy_sig_pkg.sv
// Shared constants and helpers for the 802.11a SIGNAL field serializer.
// The optional RATE check in the top is enabled by defining SIG_RATE_CHECK_EN.
package phy_sig_pkg;

    localparam int SIG_RATE_W       = 4;
    localparam int SIG_LEN_W        = 12;
    localparam int SIG_BITS         = 24;
    localparam int SIG_PARITY_POS   = 17;
    localparam int SIG_TAIL_BITS    = 6;
    localparam int SIG_RESERVED_POS = 4;

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_SEND = 1'b1;

    // Every legal 802.11a RATE code has R4 (the last-sent bit, rate[0]) set.
    function automatic logic sig_rate_valid(input logic [SIG_RATE_W-1:0] rate);
        return rate[0];
    endfunction

endpackage

// File: rtl/sig_field_serializer_bit_cnt.sv
// Modulo-N bit index counter for the SIGNAL serializer; wraps to 0 on run at N-1.
module sig_bit_cnt #(
    parameter int N = 24,
    parameter int W = 5
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_run,
    output logic [W-1:0] o_cnt,
    output logic         o_zero,
    output logic         o_at_last
);

    logic [W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_run) begin
            r_cnt <= (r_cnt == W'(N - 1)) ? '0 : r_cnt + 1'b1;
        end
    end

    assign o_cnt     = r_cnt;
    assign o_zero    = (r_cnt == '0);
    assign o_at_last = (r_cnt == W'(N - 1));

endmodule

// File: rtl/sig_field_serializer.sv
// Builds the 24-bit 802.11a SIGNAL field and streams it LSB-first over valid/ready.
// Define SIG_RATE_CHECK_EN to reject RATE codes with R4==0 (err pulse, no frame).
module sig_field_serializer
    import phy_sig_pkg::*;
#(
    parameter int RATE_W = SIG_RATE_W,
    parameter int LEN_W  = SIG_LEN_W,
    localparam int PAR_POS = RATE_W + 1 + LEN_W,
    localparam int FIELD_W = PAR_POS + 1 + SIG_TAIL_BITS,
    localparam int IDX_W   = $clog2(FIELD_W)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic [RATE_W-1:0] rate,
    input  logic [LEN_W-1:0]  length,
    output logic              bit_out,
    output logic              bit_valid,
    input  logic              bit_ready,
    output logic [IDX_W-1:0]  bit_idx,
    output logic              bit_last,
    output logic              done,
    output logic              err
);

    logic [0:0]         r_state;
    logic [FIELD_W-1:0] r_sreg;
    logic               r_done;

    logic [RATE_W-1:0]  w_rate_rev;
    logic [PAR_POS-1:0] w_hdr;
    logic               w_parity;
    logic [FIELD_W-1:0] w_field;
    logic               w_load;
    logic               w_rate_ok;
    logic               w_start;
    logic               w_xfer;
    logic [IDX_W-1:0]   w_idx;
    logic               w_zero;
    logic               w_at_last;

    // R1 is rate[3] but goes out first, so the RATE nibble is bit-reversed into the field.
    for (genvar gi = 0; gi < RATE_W; gi++) begin : g_rate_rev
        assign w_rate_rev[gi] = rate[RATE_W-1-gi];
    end

    assign w_hdr    = {length, 1'b0, w_rate_rev};
    assign w_parity = ^w_hdr;
    assign w_field  = {{SIG_TAIL_BITS{1'b0}}, w_parity, w_hdr};

    assign req_ready = rst & (r_state == ST_IDLE);
    assign w_load    = req_valid & req_ready;
    assign w_start   = w_load & w_rate_ok;
    assign w_xfer    = (r_state == ST_SEND) & bit_ready;

`ifdef SIG_RATE_CHECK_EN
    logic r_err;

    assign w_rate_ok = sig_rate_valid(rate);

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_err <= 1'b0;
        end else begin
            r_err <= w_load & ~w_rate_ok;
        end
    end

    assign err = r_err;
`else
    assign w_rate_ok = 1'b1;
    assign err       = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state <= ST_IDLE;
            r_sreg  <= '0;
            r_done  <= 1'b0;
        end else begin
            r_done <= w_xfer & w_at_last;
            if (w_start) begin
                r_sreg  <= w_field;
                r_state <= ST_SEND;
            end else if (w_xfer) begin
                r_sreg <= r_sreg >> 1;
                if (w_at_last) begin
                    r_state <= ST_IDLE;
                end
            end
        end
    end

    // The index normally wraps to 0 at frame end; clearing on load only matters if it did not.
    sig_bit_cnt #(
        .N (FIELD_W),
        .W (IDX_W)
    ) u_bit_cnt (
        .clk       (clk),
        .rst       (rst),
        .i_clr     (w_start & ~w_zero),
        .i_run     (w_xfer),
        .o_cnt     (w_idx),
        .o_zero    (w_zero),
        .o_at_last (w_at_last)
    );

    assign bit_out   = r_sreg[0];
    assign bit_valid = (r_state == ST_SEND);
    assign bit_idx   = w_idx;
    assign bit_last  = (r_state == ST_SEND) && w_at_last;
    assign done      = r_done;

endmodule

// File: tb/tb_sig_field_serializer.sv
// Directed testbench for sig_field_serializer; expected streams are hand-written bit strings.
module tb_sig_field_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic [3:0]  rate = 4'd0;
    logic [11:0] length = 12'd0;
    logic        bit_out;
    logic        bit_valid;
    logic        bit_ready = 1'b0;
    logic [4:0]  bit_idx;
    logic        bit_last;
    logic        done;
    logic        err;

    int checks = 0;
    int errors = 0;

    // Streams written in transmit order: leftmost character is bit 0.
    logic [0:23] s1;
    logic [0:23] s2;
    logic [0:23] s0;

    sig_field_serializer dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .rate      (rate),
        .length    (length),
        .bit_out   (bit_out),
        .bit_valid (bit_valid),
        .bit_ready (bit_ready),
        .bit_idx   (bit_idx),
        .bit_last  (bit_last),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic send_req(input logic [3:0] r, input logic [11:0] l);
        rate      = r;
        length    = l;
        req_valid = 1'b1;
        chk("req_ready_idle", req_ready, 1);
        tick;
        req_valid = 1'b0;
        rate      = 4'($urandom);
        length    = 12'($urandom);
        $display("req rate=%b length=%0d accepted", r, l);
        chk("first_bit_valid", bit_valid, 1);
        chk("first_bit_idx", bit_idx, 0);
        chk("req_ready_busy", req_ready, 0);
    endtask

    task automatic run_frame(input logic [0:23] exp, input bit rnd);
        int n = 0;
        int cyc = 0;
        while (n < 24 && cyc < 400) begin
            cyc++;
            bit_ready = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (bit_ready) begin
                chk("bit_out", bit_out, exp[n]);
                chk("bit_idx", bit_idx, n);
                chk("bit_last", bit_last, n == 23);
                chk("bit_valid", bit_valid, 1);
                n++;
                tick;
            end else begin
                tick;
                chk("stall_out", bit_out, exp[n]);
                chk("stall_idx", bit_idx, n);
                chk("stall_valid", bit_valid, 1);
            end
        end
        bit_ready = 1'b0;
        $display("frame %b: %0d transfers in %0d cycles", exp, n, cyc);
        chk("xfer_count", n, 24);
        chk("done_pulse", done, 1);
        chk("done_valid_low", bit_valid, 0);
        chk("done_req_ready", req_ready, 1);
        chk("done_idx", bit_idx, 0);
        tick;
        chk("done_clear", done, 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        s1 = 24'b1101_0_001001100000_0_000000;
        s2 = 24'b1111_0_100000000000_1_000000;
        s0 = 24'b0000_0_001001100000_1_000000;

        // Reset state
        rst = 1'b0;
        tick;
        tick;
        chk("rst_req_ready", req_ready, 0);
        chk("rst_bit_valid", bit_valid, 0);
        chk("rst_bit_idx", bit_idx, 0);
        chk("rst_done", done, 0);
        chk("rst_err", err, 0);
        chk("rst_bit_out", bit_out, 0);
        rst = 1'b1;
        #1;
        chk("post_rst_req_ready", req_ready, 1);
        tick;

        // 1: rate 1101, length 100, full throughput
        send_req(4'b1101, 12'd100);
        run_frame(s1, 1'b0);

        // 2: rate 1111, length 1, parity set
        send_req(4'b1111, 12'd1);
        run_frame(s2, 1'b0);

        // 3: same as 1 with random stalls
        send_req(4'b1101, 12'd100);
        run_frame(s1, 1'b1);

        // 4: reset at bit_idx 10
        send_req(4'b1101, 12'd100);
        bit_ready = 1'b1;
        repeat (10) tick;
        chk("mid_idx", bit_idx, 10);
        chk("mid_bit", bit_out, s1[10]);
        rst = 1'b0;
        #1;
        chk("mid_rst_req_ready", req_ready, 0);
        tick;
        rst = 1'b1;
        bit_ready = 1'b0;
        #1;
        chk("mid_rst_valid", bit_valid, 0);
        chk("mid_rst_idx", bit_idx, 0);
        chk("mid_rst_done", done, 0);
        chk("mid_rst_bit_out", bit_out, 0);
        chk("mid_rst_req_ready_up", req_ready, 1);
        tick;
        chk("mid_rst_no_done", done, 0);
        $display("mid-frame reset at idx 10 handled");
        send_req(4'b1111, 12'd1);
        run_frame(s2, 1'b0);

        // 5: req_valid held across two frames, inputs changed mid-frame
        rate      = 4'b1101;
        length    = 12'd100;
        req_valid = 1'b1;
        chk("b2b_req_ready", req_ready, 1);
        tick;
        rate   = 4'b1111;
        length = 12'd1;
        chk("b2b_first_valid", bit_valid, 1);
        run_frame(s1, 1'b0);
        req_valid = 1'b0;
        chk("b2b_second_valid", bit_valid, 1);
        chk("b2b_second_idx", bit_idx, 0);
        run_frame(s2, 1'b0);

        // 6: RATE 0000
`ifdef SIG_RATE_CHECK_EN
        rate      = 4'b0000;
        length    = 12'd100;
        req_valid = 1'b1;
        chk("bad_rate_req_ready", req_ready, 1);
        tick;
        req_valid = 1'b0;
        chk("bad_rate_err", err, 1);
        chk("bad_rate_valid", bit_valid, 0);
        chk("bad_rate_req_ready_after", req_ready, 1);
        tick;
        chk("bad_rate_err_clear", err, 0);
        chk("bad_rate_no_done", done, 0);
        chk("bad_rate_valid_after", bit_valid, 0);
        $display("rate 0000 rejected");
`else
        send_req(4'b0000, 12'd100);
        chk("rate0_no_err", err, 0);
        run_frame(s0, 1'b0);
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
